mips_multicycle_ctrl: RTL
=========================

Name:
mips_multicycle_ctrl

Overview:
- Sequential main control unit for the multi-cycle variant of the MIPS core.
- Sits directly upstream of the ALU control stage: produces the 2-bit alu_op that stage consumes (with op_code/funct), plus all datapath enables and muxes.
- Moore FSM stepping one state per clock, driven by the opcode of the latched instruction register.

Parameters:
- STATE_W, 4, width of the state register and debug state port.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_code  input  6  instr[31:26] from the instruction register, valid from DECODE onward.
- mem_ready  input  1  memory handshake; present only with MEM_WAIT_EN.
- pc_write  output  1  unconditional PC load.
- branch  output  1  PC load qualified by ALU zero (beq).
- i_or_d  output  1  memory address: 0 = PC, 1 = ALU out.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  instruction register load.
- mem_to_reg  output  1  register write data: 1 = MDR, 0 = ALU out.
- reg_dst  output  1  destination: 1 = rd, 0 = rt.
- reg_write  output  1  register file write.
- alu_src_a  output  1  0 = PC, 1 = rs.
- alu_src_b  output  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2.
- pc_src  output  2  00 = ALU result, 01 = ALU out reg, 10 = jump target.
- alu_op  output  2  00 add, 01 sub, 10 use funct, 11 use opcode (andi/ori/slti).
- illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode.
- state  output  STATE_W  current state, for debug.

Behaviour:
- States and encodings: RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, IEXEC 10, LEXEC 11, IWB 12, JUMP 13. Encodings 14/15 go to FETCH.
- rst_n low: state = RESET asynchronously. In RESET every output is 0 and state = 0.
- First clock after rst_n rises: RESET -> FETCH.
- Reset asserted mid-instruction aborts it at once. No partial write is asserted after the reset edge.
- All outputs decode from the state only. Any output not listed for a state is 0.
  - FETCH: mem_read, ir_write, pc_write; alu_src_b=01; alu_op=00; pc_src=00.
  - DECODE: alu_src_b=11; alu_op=00.
  - MEMADR: alu_src_a=1; alu_src_b=10; alu_op=00.
  - MEMRD: mem_read; i_or_d.
  - MEMWB: reg_write; mem_to_reg; reg_dst=0.
  - MEMWR: mem_write; i_or_d.
  - EXEC: alu_src_a=1; alu_src_b=00; alu_op=10.
  - ALUWB: reg_write; reg_dst=1.
  - BRANCH: alu_src_a=1; alu_src_b=00; alu_op=01; pc_src=01; branch.
  - IEXEC: alu_src_a=1; alu_src_b=10; alu_op=00.
  - LEXEC: as IEXEC but alu_op=11.
  - IWB: reg_write; reg_dst=0.
  - JUMP: pc_write; pc_src=10.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op_code: 000000 -> EXEC; 100011/101011 -> MEMADR; 000100 -> BRANCH; 001000 -> IEXEC; 001100/001101/001010 -> LEXEC; 000010 -> JUMP; any other -> FETCH with illegal_op=1.
  - MEMADR -> MEMRD (lw) or MEMWR (sw), selected by op_code.
  - MEMRD -> MEMWB.
  - EXEC -> ALUWB.
  - IEXEC and LEXEC -> IWB.
  - MEMWB, MEMWR, ALUWB, IWB, BRANCH and JUMP -> FETCH.
- Cycles per instruction: R/addi/logical-imm/sw 4, lw 5, beq/j 3, illegal 2.

Optional Feature:
- MIPS_MEM_WAIT_EN defined:
  - mem_ready port exists.
  - FETCH, MEMRD and MEMWR hold their state while mem_ready=0, with mem_read/mem_write held asserted.
  - In FETCH, ir_write and pc_write assert only in the cycle mem_ready=1.
- Undefined: no mem_ready port; every memory state lasts exactly one cycle.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J)
  - alu_op constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_OPCODE)
  - alu_src_b and pc_src select constants
- Sub-module mips_ctrl_outdec: purely combinational state -> output decode. The top keeps the state register and next-state logic.

Test Plan:
- Hold rst_n=0 for 3 cycles, then release -> all outputs 0 during reset; state goes 0 -> 1 on first edge.
- op_code=000000 -> states FETCH, DECODE, EXEC, ALUWB; alu_op=10 in EXEC; reg_write=1, reg_dst=1 in ALUWB; back in FETCH on cycle 5.
- op_code=100011 -> 5-cycle sequence ending in MEMWB with mem_to_reg=1, reg_dst=0.
- op_code=101011 -> MEMWR with mem_write=1, i_or_d=1.
- op_code=001101 -> LEXEC with alu_op=11, alu_src_b=10, then IWB.
- op_code=000100 -> BRANCH with alu_op=01, branch=1, pc_src=01.
- op_code=000010 -> JUMP with pc_src=10, pc_write=1.
- op_code=111111 -> illegal_op pulses for one cycle in DECODE, then FETCH.
- rst_n dropped during MEMWR -> mem_write falls immediately and state=0.
- With MIPS_MEM_WAIT_EN: mem_ready low for 3 cycles in FETCH -> state stays 1 and ir_write=0 until mem_ready=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: states, opcodes,
// ALU-op codes, datapath select codes and the bundled control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_IEXEC  = 4'd10,
        S_LEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_JUMP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_OPCODE = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore output decode: maps the current FSM state to the datapath control word.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_LEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_OPCODE;
            end
            S_IWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM (state register + next-state logic).
// Optional memory wait handshake enabled by defining MIPS_MEM_WAIT_EN.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op_code,
`ifdef MIPS_MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    output logic               pc_write,
    output logic               branch,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [1:0]         alu_op,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;
    logic   mem_ok;
    logic   fetch_stall;

`ifdef MIPS_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_RESET;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        illegal_op = 1'b0;
        case (state_reg)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  state_next = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_code)
                    OP_RTYPE:              state_next = S_EXEC;
                    OP_LW, OP_SW:          state_next = S_MEMADR;
                    OP_BEQ:                state_next = S_BRANCH;
                    OP_ADDI:               state_next = S_IEXEC;
                    OP_ANDI, OP_ORI,
                    OP_SLTI:               state_next = S_LEXEC;
                    OP_J:                  state_next = S_JUMP;
                    default: begin
                        state_next = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_next = (op_code == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_next = mem_ok ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_ALUWB;
            S_IEXEC,
            S_LEXEC:  state_next = S_IWB;
            default:  state_next = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state (state_reg),
        .ctrl  (ctrl)
    );

    // While FETCH waits on memory, the PC and IR must not capture stale data.
    assign fetch_stall = (state_reg == S_FETCH) && !mem_ok;

    assign pc_write   = ctrl.pc_write & ~fetch_stall;
    assign ir_write   = ctrl.ir_write & ~fetch_stall;
    assign branch     = ctrl.branch;
    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_dst    = ctrl.reg_dst;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign alu_op     = ctrl.alu_op;
    assign state      = STATE_W'(state_reg);

endmodule
